// File: rtl/uart_alu_interface.sv
// Responder side of the host<->ALU UART link: gathers A, B and opcode bytes, then returns the ALU result.
// Optional inter-byte timeout is enabled by defining INTERFACE_TIMEOUT_EN.
module uart_alu_interface #(
    parameter int N_BITS_DATA    = 8,
    parameter int N_BITS_OP      = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rx_done_tick_i,
    input  logic [N_BITS_DATA-1:0] rx_data_i,
    input  logic [N_BITS_DATA-1:0] alu_result_i,
    input  logic                   tx_done_tick_i,
    output logic [N_BITS_DATA-1:0] data_a_o,
    output logic [N_BITS_DATA-1:0] data_b_o,
    output logic [N_BITS_OP-1:0]   op_o,
    output logic                   tx_start_o,
    output logic [N_BITS_DATA-1:0] tx_data_o,
    output logic                   busy_o,
    output logic                   overrun_o
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t state;
    state_t next_state;

    assign busy_o = (state == EXEC) || (state == SEND) || (state == WAIT_TX);

`ifdef INTERFACE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] timeout_cnt;
    logic             timeout_hit;

    // A byte arriving on the terminal count wins over the timeout.
    assign timeout_hit = ((state == WAIT_B) || (state == WAIT_OP)) &&
                         !rx_done_tick_i && (timeout_cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            timeout_cnt <= '0;
        end else if (rx_done_tick_i || timeout_hit ||
                     ((state != WAIT_B) && (state != WAIT_OP))) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`endif

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            WAIT_A: begin
                if (rx_done_tick_i) next_state = WAIT_B;
            end
            WAIT_B: begin
                if (rx_done_tick_i) next_state = WAIT_OP;
`ifdef INTERFACE_TIMEOUT_EN
                else if (timeout_hit) next_state = WAIT_A;
`endif
            end
            WAIT_OP: begin
                if (rx_done_tick_i) next_state = EXEC;
`ifdef INTERFACE_TIMEOUT_EN
                else if (timeout_hit) next_state = WAIT_A;
`endif
            end
            EXEC:    next_state = SEND;
            SEND:    next_state = WAIT_TX;
            WAIT_TX: begin
                if (tx_done_tick_i) next_state = WAIT_A;
            end
            default: next_state = WAIT_A;
        endcase
    end

    // NOTE: state and output registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= WAIT_A;
            data_a_o   <= '0;
            data_b_o   <= '0;
            op_o       <= '0;
            tx_start_o <= 1'b0;
            tx_data_o  <= '0;
            overrun_o  <= 1'b0;
        end else begin
            state <= next_state;
            if (rx_done_tick_i) begin
                case (state)
                    WAIT_A:  data_a_o <= rx_data_i;
                    WAIT_B:  data_b_o <= rx_data_i;
                    WAIT_OP: op_o     <= rx_data_i[N_BITS_OP-1:0];
                    default: overrun_o <= 1'b1;
                endcase
            end
            if (state == EXEC) tx_data_o <= alu_result_i;
            // Registered start pulse lands in the third cycle after the op byte is sampled.
            tx_start_o <= (state == SEND);
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Randomised scoreboard bench for uart_alu_interface with a behavioural ALU and byte-stream model.
// Honours INTERFACE_TIMEOUT_EN in its reference model (timeout set to 16 cycles).
module tb_uart_alu_interface;

    localparam int TMO = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done_tick_i = 1'b0;
    logic [7:0] rx_data_i = '0;
    logic [7:0] alu_result_i;
    logic       tx_done_tick_i = 1'b0;
    logic [7:0] data_a_o;
    logic [7:0] data_b_o;
    logic [5:0] op_o;
    logic       tx_start_o;
    logic [7:0] tx_data_o;
    logic       busy_o;
    logic       overrun_o;

    uart_alu_interface #(
        .N_BITS_DATA(8),
        .N_BITS_OP(6),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_done_tick_i(rx_done_tick_i),
        .rx_data_i(rx_data_i),
        .alu_result_i(alu_result_i),
        .tx_done_tick_i(tx_done_tick_i),
        .data_a_o(data_a_o),
        .data_b_o(data_b_o),
        .op_o(op_o),
        .tx_start_o(tx_start_o),
        .tx_data_o(tx_data_o),
        .busy_o(busy_o),
        .overrun_o(overrun_o)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            6'h20:   return 8'(a + b);
            6'h22:   return 8'(a - b);
            6'h03:   return 8'(sa >>> b);
            6'h02:   return 8'(a >> b);
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result_i = alu(data_a_o, data_b_o, op_o);

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         starts_seen = 0;
    int         expected_starts = 0;
    logic [7:0] pend[$];
    bit         model_busy = 1'b0;
    bit         ovr_exp = 1'b0;
    int         last_rx = 0;

    always @(negedge clock) begin
        exp_t e;
        if (reset && tx_start_o) begin
            if (sb.size() == 0) begin
                check("spurious_tx_start", 1, 0);
            end else begin
                e = sb.pop_front();
                check("tx_data", tx_data_o, e.res);
                check("data_a", data_a_o, e.a);
                check("data_b", data_b_o, e.b);
                check("op", op_o, e.op);
                check("start_cycle", cyc, e.cyc);
                starts_seen++;
            end
        end
    end

    // Called at a negedge; the byte is sampled on the following posedge.
    task automatic drive_rx(input logic [7:0] b);
        rx_data_i      = b;
        rx_done_tick_i = 1'b1;
        @(negedge clock);
        rx_done_tick_i = 1'b0;
    endtask

    // Reference model: bytes accumulate into triples while idle; any byte while busy is an overrun.
    task automatic model_rx(input logic [7:0] b);
        exp_t e;
        if (model_busy) begin
            ovr_exp = 1'b1;
            check("overrun_set", overrun_o, 1);
        end else begin
`ifdef INTERFACE_TIMEOUT_EN
            if (pend.size() != 0 && (cyc - last_rx) > TMO) pend.delete();
`endif
            pend.push_back(b);
            last_rx = cyc;
            case (pend.size())
                1: check("latch_a", data_a_o, b);
                2: check("latch_b", data_b_o, b);
                default: begin
                    check("latch_op", op_o, b[5:0]);
                    e.a   = pend[0];
                    e.b   = pend[1];
                    e.op  = b[5:0];
                    e.res = alu(pend[0], pend[1], b[5:0]);
                    // Start is high in the third cycle after the sampling edge.
                    e.cyc = cyc + 2;
                    sb.push_back(e);
                    expected_starts++;
                    model_busy = 1'b1;
                    pend.delete();
                end
            endcase
        end
    endtask

    task automatic finish_txn(input bit ovr, input bit comb);
        int waited;
        logic [7:0] b;
        waited = 0;
        while (starts_seen < expected_starts && waited < 20) begin
            @(posedge clock);
            waited++;
        end
        @(negedge clock);
        check("tx_start_seen", starts_seen, expected_starts);
        check("busy_in_wait_tx", busy_o, 1);
        if (ovr) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            drive_rx(8'h55);
            model_rx(8'h55);
            check("busy_hold_on_overrun", busy_o, 1);
        end
        repeat ($urandom_range(0, 3)) @(negedge clock);
        b = 8'($urandom);
        tx_done_tick_i = 1'b1;
        if (comb) begin
            rx_data_i      = b;
            rx_done_tick_i = 1'b1;
        end
        @(negedge clock);
        tx_done_tick_i = 1'b0;
        rx_done_tick_i = 1'b0;
        if (comb) model_rx(b);
        model_busy = 1'b0;
        check("busy_after_tx_done", busy_o, 0);
        check("overrun_flag", overrun_o, ovr_exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit ovr, input bit comb);
        repeat (gap) @(negedge clock);
        drive_rx(b);
        model_rx(b);
        if (model_busy) finish_txn(ovr, comb);
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        @(negedge clock);
        check("reset_outputs",
              {data_a_o, data_b_o, op_o, tx_start_o, tx_data_o, busy_o, overrun_o}, 64'd0);
        reset       = 1'b1;
        pend.delete();
        model_busy  = 1'b0;
        ovr_exp     = 1'b0;
    endtask

    task automatic flush();
        while (pend.size() != 0) send_byte(8'($urandom), 0, 1'b0, 1'b0);
    endtask

    logic [5:0] ops [0:7] = '{6'h20, 6'h22, 6'h03, 6'h02, 6'h24, 6'h25, 6'h26, 6'h27};

    initial begin
        logic [5:0] op;
        @(negedge clock);
        reset_dut();

        send_byte(8'h07, 0, 1'b0, 1'b0);
        send_byte(8'h03, 0, 1'b0, 1'b0);
        send_byte(8'h20, 0, 1'b0, 1'b0);

        send_byte(8'h03, 1, 1'b0, 1'b0);
        send_byte(8'h07, 0, 1'b0, 1'b0);
        send_byte(8'h22, 2, 1'b0, 1'b0);

        send_byte(8'h05, 0, 1'b0, 1'b0);
        send_byte(8'h01, 0, 1'b0, 1'b0);
        send_byte(8'hE2, 0, 1'b0, 1'b0);

        send_byte(8'h12, 0, 1'b0, 1'b0);
        send_byte(8'h34, 0, 1'b0, 1'b0);
        send_byte(8'h20, 0, 1'b1, 1'b0);
        send_byte(8'h01, 0, 1'b0, 1'b0);
        send_byte(8'h01, 0, 1'b0, 1'b0);
        send_byte(8'h20, 0, 1'b0, 1'b0);

        send_byte(8'h10, 0, 1'b0, 1'b0);
        send_byte(8'h20, 0, 1'b0, 1'b0);
        @(negedge clock);
        reset_dut();

        tx_done_tick_i = 1'b1;
        @(negedge clock);
        tx_done_tick_i = 1'b0;
        check("tx_done_ignored_idle", busy_o, 0);
        send_byte(8'h11, 0, 1'b0, 1'b0);
        tx_done_tick_i = 1'b1;
        @(negedge clock);
        tx_done_tick_i = 1'b0;
        check("tx_done_ignored_wait_b", busy_o, 0);
        send_byte(8'h22, 0, 1'b0, 1'b0);
        send_byte(8'h20, 0, 1'b0, 1'b0);

        send_byte(8'h09, 0, 1'b0, 1'b0);
        send_byte(8'h02, TMO, 1'b0, 1'b0);
        send_byte(8'h03, 0, 1'b0, 1'b0);
        send_byte(8'h20, 0, 1'b0, 1'b0);
        flush();

        send_byte(8'h40, 0, 1'b0, 1'b0);
        send_byte(8'h02, 0, 1'b0, 1'b0);
        send_byte(8'h03, 0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 7)];
            send_byte(8'($urandom), $urandom_range(0, 3), 1'b0, 1'b0);
            send_byte(8'($urandom), $urandom_range(0, 3), 1'b0, 1'b0);
            send_byte({2'($urandom), op}, $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        end
        flush();

        repeat (5) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
